// File: rtl/demux_striper.sv
// demux_striper: registered 1-to-2 byte demultiplexer.
// Stripes an upstream valid-qualified stream alternately onto lane 0 and
// lane 1 (starting with lane 0), with a one-entry holding register that
// absorbs a beat while the selected lane is paused.
// Optional feature macro: DEMUX_BEAT_COUNT_EN adds count_0 / count_1, the
// 8-bit wrapping per-lane beat counters.
//
// state | meaning
// SEND  | ready for upstream; an accepted beat goes straight to lane sel
// HOLD  | one beat parked in hold_reg waiting for lane sel to unpause
module demux_striper #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  pause_0,
  input  logic                  pause_1,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic                  valid_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  valid_out_1,
`ifdef DEMUX_BEAT_COUNT_EN
  output logic                  sel_out,
  output logic [7:0]            count_0,
  output logic [7:0]            count_1
`else
  output logic                  sel_out
`endif
);

  typedef enum logic {SEND = 1'b0, HOLD = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic                  sel;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  pause_sel;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  load_hold;

  // Only the pause of the lane currently selected matters.
  assign pause_sel = sel ? pause_1 : pause_0;
  assign ready_in  = (state == SEND) && !reset;
  assign sel_out   = sel;

  // Next-state logic: decide whether a beat is written to a lane this cycle.
  always_comb begin
    next_state = state;
    load_hold  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = hold_reg;
    case (state)
      SEND: begin
        if (valid_in) begin
          if (!pause_sel) begin
            wr_en   = 1'b1;
            wr_data = data_in;
          end else begin
            load_hold  = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (!pause_sel) begin
          wr_en      = 1'b1;
          wr_data    = hold_reg;
          next_state = SEND;
        end
      end
      default: next_state = SEND;
    endcase
  end

  // FSM state, lane select and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEND;
      sel      <= 1'b0;
      hold_reg <= '0;
    end else begin
      state <= next_state;
      if (wr_en) sel <= ~sel;
      if (load_hold) hold_reg <= data_in;
    end
  end

  // Lane output registers; strobes last exactly one cycle per written beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_0  <= '0;
      valid_out_0 <= 1'b0;
      data_out_1  <= '0;
      valid_out_1 <= 1'b0;
    end else begin
      valid_out_0 <= wr_en && !sel;
      valid_out_1 <= wr_en && sel;
      if (wr_en && !sel) data_out_0 <= wr_data;
      if (wr_en && sel)  data_out_1 <= wr_data;
    end
  end

`ifdef DEMUX_BEAT_COUNT_EN
  // Per-lane beat counters, bumped on the same edge as the lane strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_0 <= 8'd0;
      count_1 <= 8'd0;
    end else begin
      if (wr_en && !sel) count_0 <= count_0 + 8'd1;
      if (wr_en && sel)  count_1 <= count_1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_striper.sv
// Directed testbench for demux_striper. Inputs change 1 ns after each rising
// edge; registered outputs are sampled at that same point.
module tb_demux_striper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       pause_0 = 1'b0;
  logic       pause_1 = 1'b0;
  logic       ready_in;
  logic [7:0] data_out_0;
  logic       valid_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_1;
  logic       sel_out;
`ifdef DEMUX_BEAT_COUNT_EN
  logic [7:0] count_0;
  logic [7:0] count_1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_d0 = 8'h00;
  logic [7:0] exp_d1 = 8'h00;

  demux_striper #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .pause_0(pause_0),
    .pause_1(pause_1),
    .data_out_0(data_out_0),
    .valid_out_0(valid_out_0),
    .data_out_1(data_out_1),
    .valid_out_1(valid_out_1),
`ifdef DEMUX_BEAT_COUNT_EN
    .sel_out(sel_out),
    .count_0(count_0),
    .count_1(count_1)
`else
    .sel_out(sel_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1, data_out_1, sel_out, ready_in} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_state got v0=%b d0=%h v1=%b d1=%h sel=%b rdy=%b want all 0",
               valid_out_0, data_out_0, valid_out_1, data_out_1, sel_out, ready_in);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready got %b want 1", ready_in);
    end
  endtask

  task automatic test_stream;
    logic [7:0] vec [4];
    logic       lane;
    vec = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
    for (int i = 0; i < 4; i++) begin
      data_in  = vec[i];
      valid_in = 1'b1;
      tick();
      lane = (i % 2) == 1;
      if (!lane) exp_d0 = vec[i];
      else       exp_d1 = vec[i];
      n_cmp++;
      if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== {!lane, exp_d0, lane, exp_d1}) begin
        n_bad++;
        $display("FAIL stream_beat%0d got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                 i, valid_out_0, data_out_0, valid_out_1, data_out_1, !lane, exp_d0, lane, exp_d1);
      end
    end
    valid_in = 1'b0;
    tick();
    n_cmp++;
    if ({valid_out_0, valid_out_1, sel_out} !== 3'b000) begin
      n_bad++;
      $display("FAIL stream_end got v0=%b v1=%b sel=%b want 0 0 0", valid_out_0, valid_out_1, sel_out);
    end
  endtask

  task automatic test_gap;
    data_in  = 8'h33;
    valid_in = 1'b1;
    tick();
    exp_d0 = 8'h33;
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1} !== {1'b1, 8'h33, 1'b0}) begin
      n_bad++;
      $display("FAIL gap_first got v0=%b d0=%h v1=%b want 1 33 0", valid_out_0, data_out_0, valid_out_1);
    end
    valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b00, exp_d0, exp_d1}) begin
        n_bad++;
        $display("FAIL gap_idle%0d got v0=%b v1=%b d0=%h d1=%h want 0 0 %h %h",
                 k, valid_out_0, valid_out_1, data_out_0, data_out_1, exp_d0, exp_d1);
      end
    end
    data_in  = 8'h44;
    valid_in = 1'b1;
    tick();
    exp_d1 = 8'h44;
    n_cmp++;
    if ({valid_out_0, valid_out_1, data_out_1} !== {1'b0, 1'b1, 8'h44}) begin
      n_bad++;
      $display("FAIL gap_second got v0=%b v1=%b d1=%h want 0 1 44", valid_out_0, valid_out_1, data_out_1);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_pause_sel;
    data_in  = 8'h11;
    valid_in = 1'b1;
    tick();
    exp_d0 = 8'h11;
    n_cmp++;
    if ({valid_out_0, data_out_0, sel_out} !== {1'b1, 8'h11, 1'b1}) begin
      n_bad++;
      $display("FAIL pause_setup got v0=%b d0=%h sel=%b want 1 11 1", valid_out_0, data_out_0, sel_out);
    end
    data_in = 8'h55;
    pause_1 = 1'b1;
    tick();
    data_in = 8'h66;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({ready_in, valid_out_0, valid_out_1, sel_out} !== 4'b0001) begin
        n_bad++;
        $display("FAIL pause_hold%0d got rdy=%b v0=%b v1=%b sel=%b want 0 0 0 1",
                 k, ready_in, valid_out_0, valid_out_1, sel_out);
      end
      tick();
    end
    pause_1 = 1'b0;
    #1;
    n_cmp++;
    if (ready_in !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_release_ready got %b want 0", ready_in);
    end
    tick();
    exp_d1 = 8'h55;
    n_cmp++;
    if ({valid_out_0, valid_out_1, data_out_1, ready_in, sel_out} !== {2'b01, 8'h55, 2'b10}) begin
      n_bad++;
      $display("FAIL pause_drain got v0=%b v1=%b d1=%h rdy=%b sel=%b want 0 1 55 1 0",
               valid_out_0, valid_out_1, data_out_1, ready_in, sel_out);
    end
    tick();
    exp_d0 = 8'h66;
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1} !== {1'b1, 8'h66, 1'b0}) begin
      n_bad++;
      $display("FAIL pause_next got v0=%b d0=%h v1=%b want 1 66 0", valid_out_0, data_out_0, valid_out_1);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_nonsel_pause;
    data_in  = 8'h12;
    valid_in = 1'b1;
    tick();
    exp_d1 = 8'h12;
    pause_1 = 1'b1;
    data_in = 8'hAA;
    #1;
    n_cmp++;
    if ({ready_in, sel_out} !== 2'b10) begin
      n_bad++;
      $display("FAIL nonsel1_ready got rdy=%b sel=%b want 1 0", ready_in, sel_out);
    end
    tick();
    exp_d0 = 8'hAA;
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1, ready_in} !== {1'b1, 8'hAA, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL nonsel1_beat got v0=%b d0=%h v1=%b rdy=%b want 1 aa 0 1",
               valid_out_0, data_out_0, valid_out_1, ready_in);
    end
    pause_1 = 1'b0;
    pause_0 = 1'b1;
    data_in = 8'hBB;
    tick();
    exp_d1 = 8'hBB;
    n_cmp++;
    if ({valid_out_0, valid_out_1, data_out_1, ready_in} !== {2'b01, 8'hBB, 1'b1}) begin
      n_bad++;
      $display("FAIL nonsel0_beat got v0=%b v1=%b d1=%h rdy=%b want 0 1 bb 1",
               valid_out_0, valid_out_1, data_out_1, ready_in);
    end
    pause_0  = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_reset_hold;
    data_in  = 8'h99;
    valid_in = 1'b1;
    pause_0  = 1'b1;
    tick();
    valid_in = 1'b0;
    n_cmp++;
    if ({ready_in, valid_out_0, valid_out_1} !== 3'b000) begin
      n_bad++;
      $display("FAIL rsthold_capture got rdy=%b v0=%b v1=%b want 0 0 0", ready_in, valid_out_0, valid_out_1);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1, data_out_1, sel_out, ready_in} !== 20'h0) begin
      n_bad++;
      $display("FAIL rsthold_clear got v0=%b d0=%h v1=%b d1=%h sel=%b rdy=%b want all 0",
               valid_out_0, data_out_0, valid_out_1, data_out_1, sel_out, ready_in);
    end
    #1 reset = 1'b0;
    pause_0 = 1'b0;
    exp_d0  = 8'h00;
    exp_d1  = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== 18'h0) begin
        n_bad++;
        $display("FAIL rsthold_nostrobe%0d got v0=%b d0=%h v1=%b d1=%h want all 0",
                 k, valid_out_0, data_out_0, valid_out_1, data_out_1);
      end
    end
    data_in  = 8'h77;
    valid_in = 1'b1;
    tick();
    exp_d0 = 8'h77;
    n_cmp++;
    if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== {1'b1, 8'h77, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL rsthold_next got v0=%b d0=%h v1=%b d1=%h want 1 77 0 00",
               valid_out_0, data_out_0, valid_out_1, data_out_1);
    end
    valid_in = 1'b0;
  endtask

`ifdef DEMUX_BEAT_COUNT_EN
  task automatic test_counters;
    reset = 1'b1;
    #1 reset = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_in = i[7:0];
      tick();
    end
    valid_in = 1'b0;
    tick();
    n_cmp++;
    if ({count_0, count_1} !== {8'd150, 8'd150}) begin
      n_bad++;
      $display("FAIL count_300 got c0=%0d c1=%0d want 150 150", count_0, count_1);
    end
    valid_in = 1'b1;
    for (int i = 0; i < 212; i++) begin
      data_in = i[7:0];
      tick();
    end
    valid_in = 1'b0;
    tick();
    n_cmp++;
    if ({count_0, count_1} !== 16'h0000) begin
      n_bad++;
      $display("FAIL count_wrap got c0=%0d c1=%0d want 0 0", count_0, count_1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_gap();
    test_pause_sel();
    test_nonsel_pause();
    test_reset_hold();
`ifdef DEMUX_BEAT_COUNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_striper.md
# demux_striper

Registered 1-to-2 demultiplexer: the transmit-side counterpart of the two-input valid-qualified byte mux. It accepts a single valid-qualified byte stream and stripes consecutive beats alternately onto lane 0 and lane 1, starting on lane 0. It honours per-lane pause (backpressure) through a one-entry holding register. It sits between the upstream byte source and the two lane inputs of the mux.

## Interface
- DATA_WIDTH, 8, width of every data bus
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  DATA_WIDTH  upstream byte
- valid_in  input  1  data_in carries a beat this cycle
- ready_in  output  1  block accepts a beat this cycle; combinational
- pause_0  input  1  lane 0 cannot take a beat this cycle
- pause_1  input  1  lane 1 cannot take a beat this cycle
- data_out_0  output  DATA_WIDTH  lane 0 byte, registered
- valid_out_0  output  1  lane 0 beat strobe, registered
- data_out_1  output  DATA_WIDTH  lane 1 byte, registered
- valid_out_1  output  1  lane 1 beat strobe, registered
- sel_out  output  1  lane that receives the next beat
- count_0, count_1  output  8  per-lane beat counters; present only with DEMUX_BEAT_COUNT_EN

## Operation
- Internal state:
  - sel: destination lane. Reset value 0.
  - FSM with states SEND and HOLD. Reset state is SEND.
  - hold_reg: DATA_WIDTH bits. Reset value 0.
- ready_in = (state == SEND) and not reset.
- SEND, with valid_in and ready_in both high (a beat is accepted):
  - If pause_sel = 0: data_out_sel <= data_in, valid_out_sel <= 1, sel toggles. State stays SEND.
  - If pause_sel = 1: hold_reg <= data_in. sel does not change. State goes to HOLD.
- SEND with valid_in = 0: no output strobe and sel does not change.
- HOLD:
  - ready_in = 0, so upstream must hold off.
  - On the first cycle with pause_sel = 0: data_out_sel <= hold_reg, valid_out_sel <= 1, sel toggles, state goes to SEND.
  - While pause_sel stays 1, the block remains in HOLD indefinitely.
- The pause of the non-selected lane is ignored at all times.
- valid_out_x is low on every cycle in which lane x is not written. data_out_x keeps its last written value when not written.
- At most one lane strobes per cycle. Beat order is preserved strictly: 0,1,0,1,…

## Timing
- Reset values: data_out_0 = data_out_1 = 0, valid_out_0 = valid_out_1 = 0, sel_out = 0, ready_in = 0 while reset is asserted, counters = 0.
- Latency without a pause: an input beat accepted at edge N appears on its lane as a one-cycle valid_out strobe after edge N. This is 1 cycle.
- Latency with a pause: the beat appears one cycle after the first edge at which pause_sel is sampled low in HOLD.
- Pause is sampled in the same cycle as acceptance. A pause rising in the accept cycle diverts the beat to hold_reg.
- Back-to-back beats: full throughput of one beat per cycle, alternating lanes, provided neither lane pauses.
- Reset asserted mid-HOLD: the held beat is discarded, sel returns to 0 and the FSM returns to SEND. Outputs clear asynchronously.
- Deassertion of reset: the first beat can be accepted on the first rising edge with reset low.

## Configuration
- DEMUX_BEAT_COUNT_EN defined:
  - count_0 and count_1 exist.
  - Each increments by 1 on the same edge that sets its valid_out_x.
  - 8-bit, wrap from 255 to 0, cleared by reset.
- DEMUX_BEAT_COUNT_EN undefined: the count ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset then stream: hold reset for 2 cycles, then drive 0xFF, 0xEE, 0xDD, 0xCC on consecutive cycles with valid_in high.
  - Required: lane 0 = FF, DD; lane 1 = EE, CC; one strobe per cycle starting 1 cycle after each accept.
  - Required: sel_out ends at 0.
- Gap in valid_in: drive 0x33, idle 2 cycles, then 0x44.
  - Required: 33 on lane 0, 44 on lane 1, no strobes during the idle cycles.
- Pause on selected lane: with sel = 1, drive 0x55 while pause_1 = 1, and hold pause_1 high for 3 cycles.
  - Required: ready_in = 0 for 3 cycles; data_out_1 = 55 strobes one cycle after pause_1 falls; the next beat 0x66 goes to lane 0.
- Pause on non-selected lane: pause_1 held high while sel = 0 and 0xAA is driven.
  - Required: AA on lane 0 after 1 cycle; ready_in stays 1.
- Reset mid-HOLD: capture 0x99 into HOLD, then pulse reset asynchronously between edges.
  - Required: all outputs 0 immediately, no later strobe of 99, and the next beat 0x77 goes to lane 0.
- Counters (DEMUX_BEAT_COUNT_EN defined): stream 300 beats with no pause.
  - Required: count_0 = count_1 = 150 mod 256 = 150; stream 212 more beats → count_0 = count_1 = 0 (256 each, wrap).
